// File: rtl/sr_latch_ctrl_pkg.sv
// rtl/sr_latch_ctrl_pkg.sv - shared types and constants for the SR latch bank controller
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } sr_state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// rtl/sr_latch_ctrl_if.sv - requester-side bundle: req/op/idx in, ack/err/busy out
interface sr_latch_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 3
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       op;
  logic [N_REQ*IDX_W-1:0] idx;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic                   busy;

  modport master (output req, output op, output idx, input ack, input err, input busy);
  modport slave  (input req, input op, input idx, output ack, output err, output busy);
endinterface

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// rtl/sr_latch_ctrl_rr_arbiter.sv - combinational round-robin arbiter
// Grants the first active request at or above ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int GNT_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GNT_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [GNT_W-1:0] gnt_idx,
  output logic             gnt_valid
);
  int               k;
  logic [GNT_W-1:0] k_s;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    k         = 0;
    k_s       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k   = (int'(ptr) + i) % N_REQ;
      k_s = GNT_W'(k);
      if (!gnt_valid && req[k_s]) begin
        gnt[k_s]  = 1'b1;
        gnt_idx   = k_s;
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - arbitrated S/R pulse sequencer with Q readback for a NOR latch bank
// Q is synchronised before use; S and R are only ever driven from the PULSE state.
module sr_latch_ctrl
  import sr_pkg::*;
#(
  parameter int N_LATCH    = 8,
  parameter int N_REQ      = 4,
  parameter int IDX_W      = 3,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_ctrl_if.slave     bus,
  output logic [N_LATCH-1:0] S,
  output logic [N_LATCH-1:0] R,
  input  logic [N_LATCH-1:0] Q
);
  localparam int GNT_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sr_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [GNT_W-1:0]   rr_ptr;
  logic [GNT_W-1:0]   cur_gnt;
  logic               cur_op;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_bad;
  logic [N_LATCH-1:0] q_meta;
  logic [N_LATCH-1:0] q_sync;
  logic [N_REQ-1:0]   ack_r;
  logic               err_r;
  logic               busy_r;

  logic [N_REQ-1:0]   gnt_onehot;
  logic [GNT_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               sel_op;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_bad;
  logic               sel_q;
  logic [N_LATCH-1:0] sel_mask;
  logic               chk_q;

  rr_arbiter #(.N_REQ(N_REQ), .GNT_W(GNT_W)) u_arb (
    .req       (bus.req),
    .ptr       (rr_ptr),
    .gnt       (gnt_onehot),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign sel_op   = |(bus.op & gnt_onehot);
  assign sel_idx  = bus.idx[gnt_idx*IDX_W +: IDX_W];
  assign sel_bad  = (32'(sel_idx) >= N_LATCH);
  assign sel_q    = sel_bad ? 1'b0 : q_sync[sel_idx];
  assign sel_mask = N_LATCH'(1) << sel_idx;
  assign chk_q    = q_sync[cur_idx];

  assign bus.ack  = ack_r;
  assign bus.err  = err_r;
  assign bus.busy = busy_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta <= '0;
      q_sync <= '0;
    end else begin
      q_meta <= Q;
      q_sync <= q_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_ptr  <= '0;
      cur_gnt <= '0;
      cur_op  <= 1'b0;
      cur_idx <= '0;
      cur_bad <= 1'b0;
      ack_r   <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      S       <= '0;
      R       <= '0;
    end else begin
      ack_r <= '0;
      err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur_gnt <= gnt_idx;
            cur_op  <= sel_op;
            cur_idx <= sel_idx;
            cur_bad <= sel_bad;
            busy_r  <= 1'b1;
            cnt     <= '0;
            // Out-of-range targets and already-correct bits skip straight to readback.
            if (sel_bad || (sel_q == sel_op)) begin
              state <= CHECK;
            end else begin
              state <= PULSE;
              S     <= (sel_op == OP_SET) ? sel_mask : '0;
              R     <= (sel_op == OP_CLR) ? sel_mask : '0;
            end
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(PULSE_CYC - 1)) begin
            S     <= '0;
            R     <= '0;
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          ack_r   <= N_REQ'(1) << cur_gnt;
          err_r   <= cur_bad | (chk_q != cur_op);
          rr_ptr  <= (32'(cur_gnt) == N_REQ - 1) ? '0 : cur_gnt + 1'b1;
          busy_r  <= 1'b0;
          cur_bad <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
